// File: rtl/seg7_scan_ctrl_pkg.sv
// +--------------------------------------------------------------------+
// | seg7_pkg : shared types and constants for the 7-segment scanner    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package seg7_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        ON    = 2'd2
    } scan_state_t;

endpackage

`default_nettype wire

// File: rtl/seg7_scan_ctrl_if.sv
// +--------------------------------------------------------------------+
// | seg7_scan_ctrl_if : CPU register bus of the 7-segment scanner      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

interface seg7_scan_ctrl_if;
    logic        we_i;
    logic        re_i;
    logic [1:0]  addr_i;
    logic [15:0] wdata_i;
    logic [15:0] rdata_o;

    modport master (output we_i, output re_i, output addr_i, output wdata_i, input rdata_o);
    modport slave  (input we_i, input re_i, input addr_i, input wdata_i, output rdata_o);
endinterface

`default_nettype wire

// File: rtl/seg7_scan_ctrl_hex_to_7seg.sv
// +--------------------------------------------------------------------+
// | hex_to_7seg : nibble to active-low {g,f,e,d,c,b,a} segments        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module hex_to_7seg
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
// +--------------------------------------------------------------------+
// | seg7_scan_ctrl : CPU-facing 4-digit multiplexed 7-segment scanner  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int CLK_HZ       = 10_000_000,
    parameter int REFRESH_HZ   = 1_000,
    parameter int BLANK_CYCLES = 100
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    seg7_scan_ctrl_if.slave         bus,
    output logic [6:0]              seg_o,
    output logic [3:0]              an_o,
    output logic                    frame_o
);

    localparam int SLOT = CLK_HZ / REFRESH_HZ;
    localparam int CW   = (SLOT > 1) ? $clog2(SLOT) : 1;

    if ((BLANK_CYCLES >= SLOT) || (SLOT < 2)) begin : g_bad_params
        $error("seg7_scan_ctrl: BLANK_CYCLES must be < SLOT and SLOT must be >= 2");
    end

    scan_state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    digit, digit_n;
    logic          load_act;
    logic          frame_pulse;

    logic [15:0]   data_stg;
    logic          ctrl_en;
    logic [3:0]    ctrl_mask;
    logic [15:0]   data_act;
    logic [3:0]    mask_act;

    logic [3:0]    cur_nibble;
    logic [6:0]    dec_seg;
    logic [6:0]    seg_n;
    logic [3:0]    an_n;
    logic [15:0]   rd_mux;

    // Register file and read port; a same-cycle read sees the pre-write value
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            data_stg    <= '0;
            ctrl_en     <= 1'b0;
            ctrl_mask   <= '0;
            bus.rdata_o <= '0;
        end else begin
            if (bus.we_i) begin
                case (bus.addr_i)
                    ADDR_DATA: data_stg <= bus.wdata_i;
                    ADDR_CTRL: begin
                        ctrl_en   <= bus.wdata_i[0];
                        ctrl_mask <= bus.wdata_i[7:4];
                    end
                    default: ;
                endcase
            end
            if (bus.re_i) begin
                bus.rdata_o <= rd_mux;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (bus.addr_i)
            ADDR_DATA:   rd_mux = data_stg;
            ADDR_CTRL:   rd_mux = {8'h00, ctrl_mask, 3'b000, ctrl_en};
            ADDR_STATUS: rd_mux = {14'b0, digit};
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            cnt      <= '0;
            digit    <= '0;
            data_act <= '0;
            mask_act <= '0;
            seg_o    <= SEG_OFF;
            an_o     <= 4'hF;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            digit <= digit_n;
            if (load_act) begin
                data_act <= data_stg;
                mask_act <= ctrl_mask;
            end
            seg_o <= seg_n;
            an_o  <= an_n;
        end
    end

    // Clearing enable wins over every other transition
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        digit_n     = digit;
        load_act    = 1'b0;
        frame_pulse = 1'b0;
        if (!ctrl_en) begin
            state_n = IDLE;
            cnt_n   = '0;
            digit_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_n  = BLANK;
                    cnt_n    = '0;
                    digit_n  = '0;
                    load_act = 1'b1;
                end
                BLANK: begin
                    cnt_n = cnt + CW'(1);
                    if (cnt == CW'(BLANK_CYCLES - 1)) begin
                        state_n = ON;
                    end
                end
                ON: begin
                    if (cnt == CW'(SLOT - 1)) begin
                        state_n = BLANK;
                        cnt_n   = '0;
                        digit_n = digit + 2'd1;
                        if (digit == 2'd3) begin
                            frame_pulse = 1'b1;
                            load_act    = 1'b1;
                        end
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    digit_n = '0;
                end
            endcase
        end
    end

    assign cur_nibble = data_act[{digit, 2'b00} +: 4];

    hex_to_7seg u_dec (
        .nibble (cur_nibble),
        .seg    (dec_seg)
    );

    always_comb begin
        seg_n = SEG_OFF;
        an_n  = 4'hF;
        if (ctrl_en && (state == ON) && !mask_act[digit]) begin
            seg_n = dec_seg;
            an_n  = ~(4'b0001 << digit);
        end
    end

    assign frame_o = frame_pulse;

endmodule

`default_nettype wire
